// File: rtl/tlv8413_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tlv8413_pkg
// Description : Shared FSM encoding, default bus timings and ns-to-cycle helper
//               for the dual DAC8413 read-back controller.
// Revision    : 1.0 - initial release
// ============================================================================
package tlv8413_pkg;

    localparam int unsigned CLK_FREQ_HZ_DEF   = 22118400;
    localparam int unsigned ADDR_SETUP_NS_DEF = 100;
    localparam int unsigned CS_RD_NS_DEF      = 500;
    localparam int unsigned CS_HOLD_NS_DEF    = 100;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_ACCESS = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_SETUP  = ST_SETUP,
        S_ACCESS = ST_ACCESS,
        S_HOLD   = ST_HOLD,
        S_DONE   = ST_DONE
    } state_t;

    // Integer clock period (truncated), then at least one cycle per phase.
    function automatic int unsigned ns_to_cnt(input int unsigned ns, input int unsigned freq);
        int unsigned period_ns;
        int unsigned cnt;
        period_ns = 1000000000 / freq;
        if (period_ns == 0) period_ns = 1;
        cnt = ns / period_ns;
        return (cnt < 1) ? 1 : cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tlv8413_next_ch.sv
`default_nettype none
// ============================================================================
// Module      : tlv8413_next_ch
// Description : Lowest-set-bit finder over the 8-channel read mask.
// Revision    : 1.0 - initial release
// ============================================================================
module tlv8413_next_ch
    import tlv8413_pkg::*;
(
    input  logic [7:0] mask,
    output logic [2:0] idx,
    output logic       any
);

    always_comb begin
        idx = 3'd0;
        any = 1'b0;
        // Scan downward so the lowest set bit is the final assignment.
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) begin
                idx = 3'(i);
                any = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tlv8413_readback_mx.sv
`default_nettype none
// ============================================================================
// Module      : tlv8413_readback_mx
// Description : Sweeps enabled channels of two bus-shared DAC8413s and returns
//               the upper 8 data bits of each. TLV8413_READBACK_CMP_EN adds an
//               expected-data compare (exp_data / mismatch ports).
// Revision    : 1.0 - initial release
// ============================================================================
module tlv8413_readback_mx
    import tlv8413_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ   = CLK_FREQ_HZ_DEF,
    parameter int unsigned ADDR_SETUP_NS = ADDR_SETUP_NS_DEF,
    parameter int unsigned CS_RD_NS      = CS_RD_NS_DEF,
    parameter int unsigned CS_HOLD_NS    = CS_HOLD_NS_DEF
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_start,
    input  logic [7:0]  ch_mask,
    input  logic [11:0] DAC8413_DB_I,
    output logic        DAC8413_RW,
    output logic        DAC8413_CS1,
    output logic        DAC8413_CS2,
    output logic        DAC8413_LDAC,
    output logic        DAC8413_A1,
    output logic        DAC8413_A0,
    output logic [7:0]  rd_data,
    output logic [2:0]  rd_ch,
    output logic        rd_valid,
    output logic        busy,
    output logic        done
`ifdef TLV8413_READBACK_CMP_EN
    ,
    input  logic [63:0] exp_data,
    output logic [7:0]  mismatch
`endif
);

    localparam int unsigned SETUP_CNT = ns_to_cnt(ADDR_SETUP_NS, CLK_FREQ_HZ);
    localparam int unsigned CS_RD_CNT = ns_to_cnt(CS_RD_NS, CLK_FREQ_HZ);
    localparam int unsigned HOLD_CNT  = ns_to_cnt(CS_HOLD_NS, CLK_FREQ_HZ);

    localparam logic [3:0] SETUP_LAST = 4'(SETUP_CNT - 1);
    localparam logic [3:0] CS_RD_LAST = 4'(CS_RD_CNT - 1);
    localparam logic [3:0] HOLD_LAST  = 4'(HOLD_CNT - 1);

    if (SETUP_CNT > 15 || CS_RD_CNT > 15 || HOLD_CNT > 15) begin : g_cnt_range_check
        $error("tlv8413_readback_mx: phase count exceeds 4-bit counter range");
    end

    state_t     r_state, w_state_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic [7:0] r_mask, w_mask_nxt;
    logic [2:0] r_ch, w_ch_nxt;
    logic [1:0] r_addr, w_addr_nxt;
    logic       r_cs1, w_cs1_nxt;
    logic       r_cs2, w_cs2_nxt;
    logic [7:0] r_rd_data, w_rd_data_nxt;
    logic [2:0] r_rd_ch, w_rd_ch_nxt;
    logic       r_rd_valid, w_rd_valid_nxt;
    logic       r_busy, w_busy_nxt;
    logic       r_done, w_done_nxt;
    logic [7:0] r_db_q;
    logic [7:0] w_scan_mask;
    logic [2:0] w_low;
    logic       w_any;
    logic       w_db_unused;
`ifdef TLV8413_READBACK_CMP_EN
    logic [7:0] r_mismatch, w_mismatch_nxt;
`endif

    assign w_db_unused = ^DAC8413_DB_I[3:0];

    // Fresh request mask in IDLE; remaining (already cleared) mask otherwise.
    assign w_scan_mask = (r_state == S_IDLE) ? ch_mask : r_mask;

    tlv8413_next_ch u_next_ch (
        .mask (w_scan_mask),
        .idx  (w_low),
        .any  (w_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_mask     <= 8'd0;
            r_ch       <= 3'd0;
            r_addr     <= 2'd0;
            r_cs1      <= 1'b1;
            r_cs2      <= 1'b1;
            r_rd_data  <= 8'd0;
            r_rd_ch    <= 3'd0;
            r_rd_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_db_q     <= 8'd0;
`ifdef TLV8413_READBACK_CMP_EN
            r_mismatch <= 8'd0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_mask     <= w_mask_nxt;
            r_ch       <= w_ch_nxt;
            r_addr     <= w_addr_nxt;
            r_cs1      <= w_cs1_nxt;
            r_cs2      <= w_cs2_nxt;
            r_rd_data  <= w_rd_data_nxt;
            r_rd_ch    <= w_rd_ch_nxt;
            r_rd_valid <= w_rd_valid_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_db_q     <= DAC8413_DB_I[11:4];
`ifdef TLV8413_READBACK_CMP_EN
            r_mismatch <= w_mismatch_nxt;
`endif
        end
    end

    // Bus outputs are registered alongside the state so CS/address line up
    // exactly with the phase the FSM is in.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_mask_nxt     = r_mask;
        w_ch_nxt       = r_ch;
        w_addr_nxt     = r_addr;
        w_cs1_nxt      = 1'b1;
        w_cs2_nxt      = 1'b1;
        w_rd_data_nxt  = r_rd_data;
        w_rd_ch_nxt    = r_rd_ch;
        w_rd_valid_nxt = 1'b0;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
`ifdef TLV8413_READBACK_CMP_EN
        w_mismatch_nxt = r_mismatch;
`endif
        case (r_state)
            S_IDLE: begin
                if (rd_start) begin
                    w_mask_nxt = ch_mask;
                    w_busy_nxt = 1'b1;
                    w_cnt_nxt  = 4'd0;
`ifdef TLV8413_READBACK_CMP_EN
                    w_mismatch_nxt = 8'd0;
`endif
                    if (w_any) begin
                        w_ch_nxt    = w_low;
                        w_addr_nxt  = w_low[1:0];
                        w_state_nxt = S_SETUP;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_SETUP: begin
                if (r_cnt == SETUP_LAST) begin
                    w_cnt_nxt   = 4'd0;
                    w_cs1_nxt   = r_ch[2];
                    w_cs2_nxt   = ~r_ch[2];
                    w_state_nxt = S_ACCESS;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            S_ACCESS: begin
                if (r_cnt == CS_RD_LAST) begin
                    w_cnt_nxt      = 4'd0;
                    w_rd_data_nxt  = r_db_q;
                    w_rd_ch_nxt    = r_ch;
                    w_rd_valid_nxt = 1'b1;
                    w_mask_nxt     = r_mask & ~(8'd1 << r_ch);
`ifdef TLV8413_READBACK_CMP_EN
                    w_mismatch_nxt[r_ch] = (r_db_q != exp_data[{r_ch, 3'b000} +: 8]);
`endif
                    w_state_nxt    = S_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                    w_cs1_nxt = r_ch[2];
                    w_cs2_nxt = ~r_ch[2];
                end
            end
            S_HOLD: begin
                if (r_cnt == HOLD_LAST) begin
                    w_cnt_nxt = 4'd0;
                    if (w_any) begin
                        w_ch_nxt    = w_low;
                        w_addr_nxt  = w_low[1:0];
                        w_state_nxt = S_SETUP;
                    end else begin
                        w_addr_nxt  = 2'd0;
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            S_DONE: begin
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
                w_addr_nxt  = 2'd0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign DAC8413_RW   = 1'b1;
    assign DAC8413_LDAC = 1'b1;
    assign DAC8413_CS1  = r_cs1;
    assign DAC8413_CS2  = r_cs2;
    assign DAC8413_A1   = r_addr[1];
    assign DAC8413_A0   = r_addr[0];
    assign rd_data      = r_rd_data;
    assign rd_ch        = r_rd_ch;
    assign rd_valid     = r_rd_valid;
    assign busy         = r_busy;
    assign done         = r_done;
`ifdef TLV8413_READBACK_CMP_EN
    assign mismatch     = r_mismatch;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tlv8413_readback_mx.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
// Module      : tb_tlv8413_readback_mx
// Description : Self-checking bench for the DAC8413 read-back controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tlv8413_readback_mx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_start = 1'b0;
    logic [7:0]  ch_mask = 8'd0;
    logic [11:0] db_i;
    logic        rw, cs1, cs2, ldac, a1, a0;
    logic [7:0]  rd_data;
    logic [2:0]  rd_ch;
    logic        rd_valid, busy, done;
`ifdef TLV8413_READBACK_CMP_EN
    logic [63:0] exp_data = 64'd0;
    logic [7:0]  mismatch;
`endif

    tlv8413_readback_mx dut (
        .clk          (clk),
        .rst          (rst),
        .rd_start     (rd_start),
        .ch_mask      (ch_mask),
        .DAC8413_DB_I (db_i),
        .DAC8413_RW   (rw),
        .DAC8413_CS1  (cs1),
        .DAC8413_CS2  (cs2),
        .DAC8413_LDAC (ldac),
        .DAC8413_A1   (a1),
        .DAC8413_A0   (a0),
        .rd_data      (rd_data),
        .rd_ch        (rd_ch),
        .rd_valid     (rd_valid),
        .busy         (busy),
        .done         (done)
`ifdef TLV8413_READBACK_CMP_EN
        ,
        .exp_data     (exp_data),
        .mismatch     (mismatch)
`endif
    );

    always #22.5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Register contents each DAC channel returns on the bus.
    logic [11:0] db_tab [8];
    initial begin
        db_tab[0] = 12'hAB0; db_tab[1] = 12'h1D2; db_tab[2] = 12'h2E4; db_tab[3] = 12'h560;
        db_tab[4] = 12'h4C5; db_tab[5] = 12'h5A7; db_tab[6] = 12'h6B9; db_tab[7] = 12'h7E3;
    end
    always_comb begin
        if (!cs2)      db_i = db_tab[{1'b1, a1, a0}];
        else if (!cs1) db_i = db_tab[{1'b0, a1, a0}];
        else           db_i = 12'h000;
    end

    function automatic int nth_ch(input logic [7:0] m, input int j);
        int seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                if (seen == j) return i;
                seen++;
            end
        end
        return 0;
    endfunction

    // Sweep timeline model: offset 0 is the first cycle after acceptance;
    // each channel takes 15 cycles, then one DONE cycle, then the done pulse.
    bit         m_active = 1'b0;
    int         m_off    = 0;
    int         m_n      = 0;
    logic [7:0] m_mask   = 8'd0;
    int         cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0;
            m_off    <= 0;
        end else if (rd_start && (!m_active || m_off == 15 * m_n + 1)) begin
            m_active <= 1'b1;
            m_off    <= 0;
            m_mask   <= ch_mask;
            m_n      <= $countones(ch_mask);
        end else if (m_active) begin
            if (m_off >= 15 * m_n + 1) m_active <= 1'b0;
            else                       m_off    <= m_off + 1;
        end
    end

    // Observation log written only by the compare process.
    int ev_ch[$];
    int ev_data[$];
    int ev_cyc[$];
    int ev_addr[$];
    int done_cnt = 0, cs1_low = 0, cs2_low = 0, busy_rise_cyc = 0, done_cyc = 0;

    initial begin
        int  j, r, ch;
        bit  insw, e_busy, e_done, e_cs1, e_cs2, e_valid;
        int  e_addr;
        int  exp_last_data, exp_last_ch;
        bit  p_cs1, p_cs2, p_busy;
        int  p_addr;
        exp_last_data = 0; exp_last_ch = 0;
        p_cs1 = 1; p_cs2 = 1; p_busy = 0; p_addr = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_last_data = 0; exp_last_ch = 0;
                check("rst_cs1", cs1, 1);
                check("rst_cs2", cs2, 1);
                check("rst_addr", {a1, a0}, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_valid", rd_valid, 0);
                check("rst_data", rd_data, 0);
                check("rst_ch", rd_ch, 0);
            end else begin
                e_busy = m_active && (m_off <= 15 * m_n);
                e_done = m_active && (m_off == 15 * m_n + 1);
                insw   = m_active && (m_off < 15 * m_n);
                j  = m_off / 15;
                r  = m_off % 15;
                ch = insw ? nth_ch(m_mask, j) : 0;
                e_cs1   = !(insw && r >= 2 && r <= 12 && ch < 4);
                e_cs2   = !(insw && r >= 2 && r <= 12 && ch >= 4);
                e_addr  = insw ? (ch % 4) : 0;
                e_valid = insw && (r == 13);
                if (e_valid) begin
                    exp_last_data = int'(db_tab[ch][11:4]);
                    exp_last_ch   = ch;
                end
                check("cyc_busy", busy, e_busy);
                check("cyc_done", done, e_done);
                check("cyc_cs1", cs1, e_cs1);
                check("cyc_cs2", cs2, e_cs2);
                check("cyc_addr", {a1, a0}, e_addr);
                check("cyc_valid", rd_valid, e_valid);
                check("cyc_data", rd_data, exp_last_data);
                check("cyc_ch", rd_ch, exp_last_ch);
                check("cyc_rw_ldac", {rw, ldac}, 2'b11);
            end
            check("one_cs_low", cs1 | cs2, 1);
            if ((p_cs1 && !cs1) || (p_cs2 && !cs2))
                check("cs_fall_addr_stable", {a1, a0}, p_addr);
            if (rd_valid) begin
                ev_ch.push_back(int'(rd_ch));
                ev_data.push_back(int'(rd_data));
                ev_cyc.push_back(cyc);
                ev_addr.push_back(int'({a1, a0}));
            end
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (busy && !p_busy) busy_rise_cyc = cyc;
            if (!cs1) cs1_low++;
            if (!cs2) cs2_low++;
            p_cs1 = cs1; p_cs2 = cs2; p_busy = busy; p_addr = int'({a1, a0});
        end
    end

    task automatic pulse_start(input logic [7:0] m);
        @(negedge clk); #1;
        ch_mask  = m;
        rd_start = 1'b1;
        @(negedge clk); #1;
        rd_start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, input string name);
        int k = 0;
        while (done_cnt == d0 && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        check({name, "_done_seen"}, done_cnt != d0, 1);
        @(negedge clk); #1;
    endtask

    initial begin
        #(45 * 20000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, d0, c1, c2, k;
        repeat (3) @(negedge clk);
        #5 rst = 1'b0;

        // 1: single channel on chip 1
        b = ev_ch.size(); d0 = done_cnt; c1 = cs1_low; c2 = cs2_low;
        pulse_start(8'h01);
        wait_done(d0, 100, "t1");
        check("t1_nvalid", ev_ch.size() - b, 1);
        check("t1_data", ev_data[b], 32'hAB);
        check("t1_ch", ev_ch[b], 0);
        check("t1_cs1_low", cs1_low - c1, 11);
        check("t1_cs2_low", cs2_low - c2, 0);
        check("t1_ndone", done_cnt - d0, 1);

        // 2: ch4 and ch7 on chip 2
        b = ev_ch.size(); d0 = done_cnt; c1 = cs1_low; c2 = cs2_low;
        pulse_start(8'h90);
        wait_done(d0, 100, "t2");
        check("t2_nvalid", ev_ch.size() - b, 2);
        check("t2_ch_a", ev_ch[b], 4);
        check("t2_ch_b", ev_ch[b + 1], 7);
        check("t2_data_a", ev_data[b], 32'h4C);
        check("t2_data_b", ev_data[b + 1], 32'h7E);
        check("t2_addr_a", ev_addr[b], 0);
        check("t2_addr_b", ev_addr[b + 1], 3);
        check("t2_spacing", ev_cyc[b + 1] - ev_cyc[b], 15);
        check("t2_cs1_low", cs1_low - c1, 0);
        check("t2_cs2_low", cs2_low - c2, 22);

        // 3: empty mask
        b = ev_ch.size(); d0 = done_cnt; c1 = cs1_low; c2 = cs2_low;
        pulse_start(8'h00);
        wait_done(d0, 20, "t3");
        check("t3_nvalid", ev_ch.size() - b, 0);
        check("t3_done_lat", done_cyc - busy_rise_cyc, 1);
        check("t3_cs_low", (cs1_low - c1) + (cs2_low - c2), 0);

        // 4: full sweep with restarts and mask changes mid-sweep
        b = ev_ch.size(); d0 = done_cnt;
        pulse_start(8'hFF);
        for (int i = 0; i < 3; i++) begin
            repeat (20) @(negedge clk);
            pulse_start(8'h02);
        end
        wait_done(d0, 200, "t4");
        check("t4_nvalid", ev_ch.size() - b, 8);
        for (int i = 0; i < 8; i++)
            if (b + i < ev_ch.size()) check("t4_order", ev_ch[b + i], i);
        repeat (5) @(negedge clk);
        check("t4_ndone", done_cnt - d0, 1);

        // 5: reset during ACCESS of ch2
        b = ev_ch.size(); d0 = done_cnt;
        pulse_start(8'h04);
        k = 0;
        while (cs1 && k < 40) begin @(negedge clk); k++; end
        check("t5_reached_access", cs1, 0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_cs1_async", cs1, 1);
        check("t5_busy_async", busy, 0);
        check("t5_data_async", rd_data, 0);
        @(negedge clk);
        #5 rst = 1'b0;
        check("t5_no_valid", ev_ch.size() - b, 0);
        check("t5_no_done", done_cnt - d0, 0);
        b = ev_ch.size(); d0 = done_cnt;
        pulse_start(8'h05);
        wait_done(d0, 100, "t5");
        check("t5_nvalid", ev_ch.size() - b, 2);
        check("t5_first_ch", ev_ch[b], 0);
        check("t5_second_data", ev_data[b + 1], 32'h2E);

`ifdef TLV8413_READBACK_CMP_EN
        // 6: compare against expected bytes, ch3 deliberately wrong
        exp_data = {32'h0, 8'h55, 8'h2E, 8'h1D, 8'hAB};
        d0 = done_cnt;
        pulse_start(8'h0F);
        wait_done(d0, 100, "t6");
        check("t6_mismatch", mismatch, 8'h08);
        d0 = done_cnt;
        pulse_start(8'h01);
        wait_done(d0, 100, "t6b");
        check("t6_mismatch_clear", mismatch, 8'h00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
